// File: rtl/cpu_pkg.sv
// Shared types for the MIPS-lite multi-cycle control unit: opcodes, FSM states,
// ALU and mux selects, and the instruction classes produced by ctrl_decode.
package cpu_pkg;

  typedef enum logic [5:0] {
    OP_ADD  = 6'd0,
    OP_ADDI = 6'd1,
    OP_SUB  = 6'd2,
    OP_SUBI = 6'd3,
    OP_MUL  = 6'd4,
    OP_MULI = 6'd5,
    OP_OR   = 6'd6,
    OP_ORI  = 6'd7,
    OP_AND  = 6'd8,
    OP_ANDI = 6'd9,
    OP_XOR  = 6'd10,
    OP_XORI = 6'd11,
    OP_LDW  = 6'd12,
    OP_STW  = 6'd13,
    OP_BZ   = 6'd14,
    OP_BEQ  = 6'd15,
    OP_JR   = 6'd16,
    OP_HALT = 6'd17
  } opcode_e;

  localparam logic [5:0] OP_LAST = 6'b010001;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_OR  = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_BR  = 2'd1,
    PC_RS  = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    SRC_RT   = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_ZERO = 2'd2
  } alu_src_e;

  typedef enum logic [2:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JR     = 3'd4,
    CLS_HALT   = 3'd5
  } op_class_e;

  function automatic logic op_is_legal(input logic [5:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decode: instruction class, ALU operation, ALU B select,
// destination register select and legality.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  output op_class_e  op_class,
  output alu_op_e    alu_op,
  output alu_src_e   alu_src,
  output logic       reg_dst_rt,
  output logic       legal
);

  always_comb begin
    op_class   = CLS_HALT;
    alu_op     = ALU_ADD;
    alu_src    = SRC_RT;
    reg_dst_rt = op[0];
    legal      = op_is_legal(op);

    // ADD..XORI come in reg/imm pairs: bit 0 picks the immediate form
    if (op <= OP_XORI) begin
      op_class = CLS_ALU;
      alu_src  = op[0] ? SRC_IMM : SRC_RT;
      case (op[3:1])
        3'd0:    alu_op = ALU_ADD;
        3'd1:    alu_op = ALU_SUB;
        3'd2:    alu_op = ALU_MUL;
        3'd3:    alu_op = ALU_OR;
        3'd4:    alu_op = ALU_AND;
        3'd5:    alu_op = ALU_XOR;
        default: alu_op = ALU_ADD;
      endcase
    end else begin
      case (op)
        OP_LDW: begin
          op_class   = CLS_LOAD;
          alu_src    = SRC_IMM;
          reg_dst_rt = 1'b1;
        end
        OP_STW: begin
          op_class = CLS_STORE;
          alu_src  = SRC_IMM;
        end
        OP_BZ: begin
          op_class = CLS_BRANCH;
          alu_op   = ALU_SUB;
          alu_src  = SRC_ZERO;
        end
        OP_BEQ: begin
          op_class = CLS_BRANCH;
          alu_op   = ALU_SUB;
          alu_src  = SRC_RT;
        end
        OP_JR:   op_class = CLS_JR;
        default: op_class = CLS_HALT;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite core: sequences fetch through
// writeback, handshakes with both memories and counts retired instructions.
//
// state  | meaning
// FETCH  | imem_req high until imem_ack; latch opcode, bump PC
// DECODE | regfile read, pick EXEC or HALT
// EXEC   | drive ALU; resolve branch / JR
// MEM    | dmem_req high until dmem_ack
// WB     | regfile write
// HALT   | stopped until reset
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       instr_op,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             alu_zero,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic [1:0]       alu_src,
  output logic             reg_we,
  output logic             reg_dst_rt,
  output logic             wb_sel_mem,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_e           state, state_nxt;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  op_class_e dec_class;
  alu_op_e   dec_alu_op;
  alu_src_e  dec_alu_src;
  logic      dec_reg_dst_rt;
  logic      dec_legal;

  ctrl_decode u_decode (
    .op         (op_q),
    .op_class   (dec_class),
    .alu_op     (dec_alu_op),
    .alu_src    (dec_alu_src),
    .reg_dst_rt (dec_reg_dst_rt),
    .legal      (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) op_q <= instr_op;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    imem_req   = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_INC;
    alu_op     = ALU_ADD;
    alu_src    = SRC_RT;
    reg_we     = 1'b0;
    reg_dst_rt = 1'b0;
    wb_sel_mem = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;

    case (state)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          pc_src    = PC_INC;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        // only a genuine HALT opcode counts as retired; undefined ones do not
        if (dec_class == CLS_HALT) begin
          state_nxt = HALT;
          retire    = (op_q == OP_HALT);
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        alu_op  = dec_alu_op;
        alu_src = dec_alu_src;
        case (dec_class)
          CLS_ALU:              state_nxt = WB;
          CLS_LOAD, CLS_STORE:  state_nxt = MEM;
          CLS_BRANCH: begin
            if (alu_zero) begin
              pc_we  = 1'b1;
              pc_src = PC_BR;
            end
            state_nxt = FETCH;
            retire    = 1'b1;
          end
          CLS_JR: begin
            pc_we     = 1'b1;
            pc_src    = PC_RS;
            state_nxt = FETCH;
            retire    = 1'b1;
          end
          default:              state_nxt = HALT;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (dec_class == CLS_STORE);
        if (dmem_ack) begin
          if (dec_class == CLS_STORE) begin
            state_nxt = FETCH;
            retire    = 1'b1;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        reg_we     = 1'b1;
        reg_dst_rt = dec_reg_dst_rt;
        wb_sel_mem = (dec_class == CLS_LOAD);
        state_nxt  = FETCH;
        retire     = 1'b1;
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase

    // strobes are suppressed for the whole reset cycle so nothing gets written
    if (reset) begin
      retire   = 1'b0;
      imem_req = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      reg_we   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  assign halted  = (state == HALT);
  assign illegal = halted && !dec_legal;
  assign retired = retired_q;

endmodule
